// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential RV32M multiply unit.
// Op encoding follows funct3[1:0] of the M-extension multiply group.
package mul_pkg;

    localparam int XLEN     = 32;
    localparam int ADDER_W  = 32;
    localparam int MUL_ITER = 32;
    localparam int CNT_W    = 5;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ABS_A,
        ST_ABS_B,
        ST_MUL,
        ST_NEG_LO,
        ST_NEG_HI,
        ST_DONE
    } mul_state_e;

endpackage

// File: rtl/adder_32bit.sv
// Ripple-free behavioural adder with carry in/out.
// The multiply unit time-shares a single instance of it.
module adder_32bit #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    output logic [WIDTH-1:0] s_o,
    output logic             c_o
);

    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, c_i};

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential RV32M multiplier: abs-value, 32 shift-add steps, negate.
// One adder is shared across all phases via a state-selected operand mux.
module mul_seq_ctrl #(
    parameter int XLEN     = 32,
    parameter int MUL_ITER = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_data_o,
    output logic            busy_o
);

    import mul_pkg::*;

    if (XLEN != ADDER_W || MUL_ITER != XLEN || MUL_ITER != mul_pkg::MUL_ITER) begin : g_cfg_err
        $error("mul_seq_ctrl: XLEN and MUL_ITER must match the adder width");
    end

    mul_state_e       state_q, state_d;
    mul_op_e          op_q;
    logic [XLEN-1:0]  mcand_q;
    logic [XLEN-1:0]  mplr_q;
    logic [XLEN-1:0]  hi_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sgn_a_q, sgn_b_q, neg_q, cy_q;

    logic [XLEN-1:0]  add_a, add_b, add_s;
    logic             add_c;
    logic             accept;
    logic             sgn_a, sgn_b;
    mul_op_e          op_in;

    assign op_in = mul_op_e'(op_i);
    assign sgn_a = rs1_i[XLEN-1] & (op_in == OP_MULH || op_in == OP_MULHSU);
    assign sgn_b = rs2_i[XLEN-1] & (op_in == OP_MULH);

    assign req_ready_o = (state_q == ST_IDLE) & rst_ni & ~flush_i;
    assign accept      = req_valid_i & req_ready_o;
    assign busy_o      = (state_q != ST_IDLE);
    assign rsp_valid_o = (state_q == ST_DONE);
    // After NEG_LO the low product word lives in the multiplier register
    assign rsp_data_o  = (op_q == OP_MUL) ? mplr_q : hi_q;

    adder_32bit #(
        .WIDTH(XLEN)
    ) u_adder (
        .a_i(add_a),
        .b_i(add_b),
        .c_i(1'b0),
        .s_o(add_s),
        .c_o(add_c)
    );

    always_comb begin
        state_d = state_q;
        add_a   = hi_q;
        add_b   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_ABS_A;
            end
            ST_ABS_A: begin
                add_a   = sgn_a_q ? ~mcand_q : mcand_q;
                add_b   = {{(XLEN-1){1'b0}}, sgn_a_q};
                state_d = ST_ABS_B;
            end
            ST_ABS_B: begin
                add_a   = sgn_b_q ? ~mplr_q : mplr_q;
                add_b   = {{(XLEN-1){1'b0}}, sgn_b_q};
                state_d = ST_MUL;
            end
            ST_MUL: begin
                add_a = hi_q;
                add_b = mplr_q[0] ? mcand_q : '0;
                if (&cnt_q) state_d = ST_NEG_LO;
            end
            ST_NEG_LO: begin
                add_a   = neg_q ? ~mplr_q : mplr_q;
                add_b   = {{(XLEN-1){1'b0}}, neg_q};
                state_d = ST_NEG_HI;
            end
            ST_NEG_HI: begin
                add_a   = neg_q ? ~hi_q : hi_q;
                add_b   = {{(XLEN-1){1'b0}}, cy_q};
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) state_d = ST_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MUL;
            mcand_q <= '0;
            mplr_q  <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            sgn_a_q <= 1'b0;
            sgn_b_q <= 1'b0;
            neg_q   <= 1'b0;
            cy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        mcand_q <= rs1_i;
                        mplr_q  <= rs2_i;
                        op_q    <= op_in;
                        sgn_a_q <= sgn_a;
                        sgn_b_q <= sgn_b;
                        neg_q   <= sgn_a ^ sgn_b;
                        hi_q    <= '0;
                        cnt_q   <= '0;
                        cy_q    <= 1'b0;
                    end
                end
                ST_ABS_A: mcand_q <= add_s;
                ST_ABS_B: mplr_q  <= add_s;
                ST_MUL: begin
                    // {hi, mplr} shifts right by one with the new partial sum on top
                    hi_q   <= {add_c, add_s[XLEN-1:1]};
                    mplr_q <= {add_s[0], mplr_q[XLEN-1:1]};
                    cnt_q  <= cnt_q + 5'd1;
                end
                ST_NEG_LO: begin
                    mplr_q <= add_s;
                    cy_q   <= add_c & neg_q;
                end
                ST_NEG_HI: hi_q <= add_s;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: products, latency, flush, hold, reset.
// Expected values are hand-computed 64-bit products.
module tb_mul_seq_ctrl;

    localparam logic [1:0] M_MUL    = 2'b00;
    localparam logic [1:0] M_MULH   = 2'b01;
    localparam logic [1:0] M_MULHSU = 2'b10;
    localparam logic [1:0] M_MULHU  = 2'b11;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;

    mul_seq_ctrl dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .op_i(op),
        .rs1_i(rs1),
        .rs2_i(rs2),
        .flush_i(flush),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data),
        .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        op = o;
        rs1 = a;
        rs2 = b;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_ready: req_ready_o=%b expected 1", req_ready);
        end
        step();
        acc_cyc = cyc;
        req_valid = 1'b0;
        op = 2'($urandom);
        rs1 = $urandom;
        rs2 = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (rsp_valid !== 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_d, input string name, output int n);
        start_op(o, a, b);
        wait_done(n);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin
            failures++;
            $display("FAIL %s: valid=%b data=%h expected valid=1 data=%h", name, rsp_valid, rsp_data, exp_d);
        end
        finish_rsp();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_release: valid=%b busy=%b expected 0 0", name, rsp_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        step();
        step();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 32'h0 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b busy=%b data=%h ready=%b expected 0 0 0 0",
                     rsp_valid, busy, rsp_data, req_ready);
        end
        rst_ni = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: req_ready_o=%b expected 1", req_ready);
        end
    endtask

    task automatic test_latency();
        int n;
        run_op(M_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_ones", n);
        checks++;
        if (n != 37) begin
            failures++;
            $display("FAIL latency: rsp_valid in cycle %0d expected 37", n);
        end
    endtask

    task automatic test_products();
        logic [1:0]  t_op[10];
        logic [31:0] t_a[10];
        logic [31:0] t_b[10];
        logic [31:0] t_e[10];
        int n;
        t_op[0] = M_MUL;    t_a[0] = 32'hFFFFFFFF; t_b[0] = 32'hFFFFFFFF; t_e[0] = 32'h00000001;
        t_op[1] = M_MULH;   t_a[1] = 32'h80000000; t_b[1] = 32'h80000000; t_e[1] = 32'h40000000;
        t_op[2] = M_MUL;    t_a[2] = 32'h80000000; t_b[2] = 32'h80000000; t_e[2] = 32'h00000000;
        t_op[3] = M_MULHSU; t_a[3] = 32'hFFFFFFFF; t_b[3] = 32'hFFFFFFFF; t_e[3] = 32'hFFFFFFFF;
        t_op[4] = M_MULH;   t_a[4] = 32'h00000000; t_b[4] = 32'h80000000; t_e[4] = 32'h00000000;
        t_op[5] = M_MUL;    t_a[5] = 32'h00000007; t_b[5] = 32'hFFFFFFFD; t_e[5] = 32'hFFFFFFEB;
        t_op[6] = M_MULH;   t_a[6] = 32'hFFFFFFF9; t_b[6] = 32'h00000003; t_e[6] = 32'hFFFFFFFF;
        t_op[7] = M_MULH;   t_a[7] = 32'hFFFFFFFF; t_b[7] = 32'hFFFFFFFF; t_e[7] = 32'h00000000;
        t_op[8] = M_MULHSU; t_a[8] = 32'h80000000; t_b[8] = 32'h00000002; t_e[8] = 32'hFFFFFFFF;
        t_op[9] = M_MULHU;  t_a[9] = 32'h80000000; t_b[9] = 32'h00000002; t_e[9] = 32'h00000001;
        for (int i = 0; i < 10; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], t_e[i], $sformatf("product_%0d", i), n);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int first;
        run_op(M_MUL, 32'h00000003, 32'h00000005, 32'h0000000F, "b2b_first", n);
        first = acc_cyc;
        run_op(M_MULHU, 32'h00010000, 32'h00010000, 32'h00000001, "b2b_second", n);
        checks++;
        if (acc_cyc - first != 38) begin
            failures++;
            $display("FAIL b2b_spacing: spacing=%0d expected 38", acc_cyc - first);
        end
    endtask

    task automatic test_flush();
        int n;
        start_op(M_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (12) step();
        flush = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        op = M_MUL;
        #1;
        checks++;
        if (busy !== 1'b1 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_cycle: busy=%b ready=%b expected 1 0", busy, req_ready);
        end
        step();
        flush = 1'b0;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle: busy=%b valid=%b expected 0 0", busy, rsp_valid);
        end
        run_op(M_MUL, 32'h00000006, 32'h00000007, 32'h0000002A, "after_flush", n);
        checks++;
        if (n != 37) begin
            failures++;
            $display("FAIL after_flush_latency: rsp_valid in cycle %0d expected 37", n);
        end
    endtask

    task automatic test_hold();
        int n;
        start_op(M_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(n);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            rs1 = $urandom;
            rs2 = $urandom;
            op = 2'($urandom);
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFFFFFE || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_%0d: valid=%b data=%h ready=%b expected 1 fffffffe 0",
                         i, rsp_valid, rsp_data, req_ready);
            end
            step();
        end
        req_valid = 1'b0;
        finish_rsp();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL hold_release: valid=%b busy=%b expected 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        start_op(M_MUL, 32'h00000003, 32'h00000005);
        step();
        checks++;
        if (busy !== 1'b1 || rsp_data !== 32'h00000005) begin
            failures++;
            $display("FAIL abs_b_state: busy=%b data=%h expected 1 00000005", busy, rsp_data);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: req_ready_o=%b expected 0", req_ready);
        end
        step();
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 32'h0 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b valid=%b data=%h ready=%b expected 0 0 0 0",
                     busy, rsp_valid, rsp_data, req_ready);
        end
        rst_ni = 1'b1;
        step();
        run_op(M_MULHSU, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, "after_reset", n);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_products();
        test_back_to_back();
        test_flush();
        test_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
